// File: rtl/reg_bus_pkg.sv
`default_nettype none
// ============================================================================
// reg_bus_pkg : shared opcodes, register indices and FSM encoding for the
//               three-register shared-bus sequencer.   Rev 1.0
// ============================================================================
package reg_bus_pkg;

    localparam logic [1:0] OP_NOP  = 2'b00;
    localparam logic [1:0] OP_LOAD = 2'b01;
    localparam logic [1:0] OP_MOVE = 2'b10;
    localparam logic [1:0] OP_SWAP = 2'b11;

    localparam logic [1:0] IDX_REG1    = 2'd0;
    localparam logic [1:0] IDX_REG2    = 2'd1;
    localparam logic [1:0] IDX_REG3    = 2'd2;
    localparam logic [1:0] IDX_ILLEGAL = 2'd3;

    localparam logic [1:0] SEL2_IDLE = 2'b11;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_ERR  = 2'd2;

    // LOAD only consults dst; MOVE and SWAP consult both indices.
    function automatic logic cmd_is_illegal(input logic [1:0] op,
                                            input logic [1:0] src,
                                            input logic [1:0] dst);
        logic r;
        r = 1'b0;
        case (op)
            OP_LOAD: r = (dst == IDX_ILLEGAL);
            OP_MOVE: r = (src == IDX_ILLEGAL) || (dst == IDX_ILLEGAL);
            OP_SWAP: r = (src == IDX_ILLEGAL) || (dst == IDX_ILLEGAL) || (src == dst);
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    // Returns {ldr_3, ldr_2, ldr_1}.
    function automatic logic [2:0] idx_onehot(input logic [1:0] idx);
        logic [2:0] r;
        case (idx)
            IDX_REG1: r = 3'b001;
            IDX_REG2: r = 3'b010;
            IDX_REG3: r = 3'b100;
            default:  r = 3'b000;
        endcase
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/xfer_step_decode.sv
`default_nettype none
// ============================================================================
// xfer_step_decode : maps (op, src, dst, step) to one datapath control word
//                    plus a last-step flag.   Rev 1.0
// ============================================================================
module xfer_step_decode
    import reg_bus_pkg::*;
(
    input  logic [1:0] i_op,
    input  logic [1:0] i_src,
    input  logic [1:0] i_dst,
    input  logic [1:0] i_step,
    output logic       o_ldr_1,
    output logic       o_ldr_2,
    output logic       o_ldr_3,
    output logic       o_sel_1,
    output logic [1:0] o_sel_2,
    output logic       o_last
);

    logic [1:0] w_tmp;
    logic [2:0] w_ldr;

    // Indices 0+1+2 sum to 3, so the spare register is 3 - src - dst.
    assign w_tmp = IDX_ILLEGAL - i_src - i_dst;

    always_comb begin
        w_ldr   = 3'b000;
        o_sel_1 = 1'b0;
        o_sel_2 = SEL2_IDLE;
        o_last  = 1'b1;
        case (i_op)
            OP_LOAD: begin
                if ((i_dst == IDX_REG1) || (i_step == 2'd0)) begin
                    w_ldr   = 3'b001;
                    o_sel_1 = 1'b1;
                    o_last  = (i_dst == IDX_REG1);
                end else begin
                    o_sel_2 = IDX_REG1;
                    w_ldr   = idx_onehot(i_dst);
                end
            end
            OP_MOVE: begin
                o_sel_2 = i_src;
                w_ldr   = idx_onehot(i_dst);
            end
            OP_SWAP: begin
                case (i_step)
                    2'd0: begin
                        o_sel_2 = i_src;
                        w_ldr   = idx_onehot(w_tmp);
                        o_last  = 1'b0;
                    end
                    2'd1: begin
                        o_sel_2 = i_dst;
                        w_ldr   = idx_onehot(i_src);
                        o_last  = 1'b0;
                    end
                    default: begin
                        o_sel_2 = w_tmp;
                        w_ldr   = idx_onehot(i_dst);
                    end
                endcase
            end
            default: ;
        endcase
    end

    assign {o_ldr_3, o_ldr_2, o_ldr_1} = w_ldr;

endmodule
`default_nettype wire

// File: rtl/reg_bus_sequencer.sv
`default_nettype none
// ============================================================================
// reg_bus_sequencer : accepts register-transfer commands and steps the
//                     data_path load enables / bus selects.   Rev 1.0
// ============================================================================
module reg_bus_sequencer
    import reg_bus_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [1:0] cmd_src,
    input  logic [1:0] cmd_dst,
    output logic       ldr_1,
    output logic       ldr_2,
    output logic       ldr_3,
    output logic       sel_1,
    output logic [1:0] sel_2,
    output logic       busy,
    output logic       done,
    output logic       err
);

    logic [1:0] r_state;
    logic [1:0] r_op;
    logic [1:0] r_src;
    logic [1:0] r_dst;
    logic [1:0] r_step;

    logic       w_idle;
    logic       w_illegal;
    logic [1:0] w_op;
    logic [1:0] w_src;
    logic [1:0] w_dst;
    logic [1:0] w_step;
    logic       w_ldr_1;
    logic       w_ldr_2;
    logic       w_ldr_3;
    logic       w_sel_1;
    logic [1:0] w_sel_2;
    logic       w_last;

    assign w_idle    = (r_state == ST_IDLE);
    assign cmd_ready = w_idle;
    assign w_illegal = cmd_is_illegal(cmd_op, cmd_src, cmd_dst);

    // Outputs are registered, so the decoder always looks one step ahead:
    // step 0 of the incoming command in IDLE, the next step while executing.
    assign w_op   = w_idle ? cmd_op  : r_op;
    assign w_src  = w_idle ? cmd_src : r_src;
    assign w_dst  = w_idle ? cmd_dst : r_dst;
    assign w_step = w_idle ? 2'd0    : r_step + 2'd1;

    xfer_step_decode u_decode (
        .i_op    (w_op),
        .i_src   (w_src),
        .i_dst   (w_dst),
        .i_step  (w_step),
        .o_ldr_1 (w_ldr_1),
        .o_ldr_2 (w_ldr_2),
        .o_ldr_3 (w_ldr_3),
        .o_sel_1 (w_sel_1),
        .o_sel_2 (w_sel_2),
        .o_last  (w_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_op    <= OP_NOP;
            r_src   <= IDX_REG1;
            r_dst   <= IDX_REG1;
            r_step  <= 2'd0;
            ldr_1   <= 1'b0;
            ldr_2   <= 1'b0;
            ldr_3   <= 1'b0;
            sel_1   <= 1'b0;
            sel_2   <= SEL2_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        r_op  <= cmd_op;
                        r_src <= cmd_src;
                        r_dst <= cmd_dst;
                        if (w_illegal) begin
                            r_state <= ST_ERR;
                            err     <= 1'b1;
                        end else begin
                            r_state <= ST_EXEC;
                            r_step  <= 2'd0;
                            ldr_1   <= w_ldr_1;
                            ldr_2   <= w_ldr_2;
                            ldr_3   <= w_ldr_3;
                            sel_1   <= w_sel_1;
                            sel_2   <= w_sel_2;
                            busy    <= 1'b1;
                            done    <= w_last;
                        end
                    end
                end
                ST_EXEC: begin
                    // done doubles as the "current step is the last" flag.
                    if (done) begin
                        r_state <= ST_IDLE;
                        ldr_1   <= 1'b0;
                        ldr_2   <= 1'b0;
                        ldr_3   <= 1'b0;
                        sel_1   <= 1'b0;
                        sel_2   <= SEL2_IDLE;
                        busy    <= 1'b0;
                        done    <= 1'b0;
                    end else begin
                        r_step <= w_step;
                        ldr_1  <= w_ldr_1;
                        ldr_2  <= w_ldr_2;
                        ldr_3  <= w_ldr_3;
                        sel_1  <= w_sel_1;
                        sel_2  <= w_sel_2;
                        done   <= w_last;
                    end
                end
                ST_ERR: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
